// File: rtl/btn_irq_pkg.sv
// Shared constants for the button interrupt controller: button count, IRQ ID
// width and the debounce windows used in simulation and on the board.
package btn_irq_pkg;
  localparam int NUM_BTN          = 5;
  localparam int IRQ_ID_W         = 3;
  localparam int DEBOUNCE_SIM     = 20;
  localparam int DEBOUNCE_BOARD   = 1_000_000;
  localparam int DEBOUNCE_DEFAULT = DEBOUNCE_SIM;
endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-flop synchroniser, persistence counter and
// stable level, plus a one-cycle pulse on the cycle the stable level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = btn_irq_pkg::DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);
  import btn_irq_pkg::*;

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= btn_i;
      r_s2 <= r_s1;
      // Any return to the accepted level restarts the persistence window.
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_at_limit) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign stable_o = r_stable;
  assign rise_o   = r_s2 & ~r_stable & w_at_limit;
endmodule

// File: rtl/btn_irq_ctrl.sv
// Button interrupt controller: debounced press edges latch into pending flags;
// enabled pending flags raise a level IRQ with the lowest active index as ID.
module btn_irq_ctrl #(
  parameter int NUM_BTN         = btn_irq_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = btn_irq_pkg::DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_BTN-1:0]               btn_i,
  input  logic                             en_we,
  input  logic [NUM_BTN-1:0]               en_wdata,
  input  logic                             clr_we,
  input  logic [NUM_BTN-1:0]               clr_wdata,
  output logic [NUM_BTN-1:0]               btn_stable_o,
  output logic [NUM_BTN-1:0]               en_o,
  output logic [NUM_BTN-1:0]               pend_o,
  output logic                             irq_o,
  output logic [btn_irq_pkg::IRQ_ID_W-1:0] irq_id_o
);
  import btn_irq_pkg::*;

  logic [NUM_BTN-1:0]  w_stable;
  logic [NUM_BTN-1:0]  w_rise;
  logic [NUM_BTN-1:0]  w_clr_mask;
  logic [NUM_BTN-1:0]  w_act;
  logic [IRQ_ID_W-1:0] w_irq_id;
  logic [NUM_BTN-1:0]  r_en;
  logic [NUM_BTN-1:0]  r_pend;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .rstn     (rstn),
      .btn_i    (btn_i[g]),
      .stable_o (w_stable[g]),
      .rise_o   (w_rise[g])
    );
  end

  assign w_clr_mask = clr_we ? clr_wdata : '0;

  // Set is OR-ed in after the clear so a same-cycle press is never lost.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_en   <= '0;
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_mask) | w_rise;
      if (en_we) begin
        r_en <= en_wdata;
      end
    end
  end

  assign w_act = r_pend & r_en;

  always_comb begin
    w_irq_id = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_irq_id = IRQ_ID_W'(i);
      end
    end
  end

  assign btn_stable_o = w_stable;
  assign en_o         = r_en;
  assign pend_o       = r_pend;
  assign irq_o        = |w_act;
  assign irq_id_o     = w_irq_id;
endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Bench for btn_irq_ctrl: directed scenarios with literal expectations, then
// random button/MMIO traffic compared every cycle to a window-based model.
module tb_btn_irq_ctrl;
  localparam int NB = 5;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NB-1:0] btn_i = '0;
  logic          en_we = 1'b0;
  logic [NB-1:0] en_wdata = '0;
  logic          clr_we = 1'b0;
  logic [NB-1:0] clr_wdata = '0;
  logic [NB-1:0] btn_stable_o;
  logic [NB-1:0] en_o;
  logic [NB-1:0] pend_o;
  logic          irq_o;
  logic [2:0]    irq_id_o;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  btn_irq_ctrl #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn_i        (btn_i),
    .en_we        (en_we),
    .en_wdata     (en_wdata),
    .clr_we       (clr_we),
    .clr_wdata    (clr_wdata),
    .btn_stable_o (btn_stable_o),
    .en_o         (en_o),
    .pend_o       (pend_o),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a button level is accepted once the synchronised input has
  // disagreed with the accepted level on each of the last D clock edges.
  logic [NB-1:0] m_s1, m_s2, m_stable, m_pend, m_en, m_rise, m_nstable, m_act;
  logic [D-1:0]  m_hist [NB];
  logic [2:0]    m_id;

  always @(posedge clk) begin
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_en = '0;
      for (int b = 0; b < NB; b++) m_hist[b] = '0;
    end else begin
      m_rise    = '0;
      m_nstable = m_stable;
      for (int b = 0; b < NB; b++) begin
        m_hist[b] = {m_hist[b][D-2:0], m_s2[b]};
        if (m_hist[b] == {D{~m_stable[b]}}) begin
          m_nstable[b] = ~m_stable[b];
          m_rise[b]    = ~m_stable[b];
        end
      end
      m_pend = (m_pend & ~(clr_we ? clr_wdata : '0)) | m_rise;
      if (en_we) m_en = en_wdata;
      m_stable = m_nstable;
      m_s2     = m_s1;
      m_s1     = btn_i;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      m_act = m_pend & m_en;
      m_id  = '0;
      for (int i = NB - 1; i >= 0; i--) if (m_act[i]) m_id = 3'(i);
      chk("stable", 32'(btn_stable_o), 32'(m_stable));
      chk("en",     32'(en_o),         32'(m_en));
      chk("pend",   32'(pend_o),       32'(m_pend));
      chk("irq",    32'(irq_o),        32'(|m_act));
      chk("irq_id", 32'(irq_id_o),     32'(m_id));
    end
  end

  initial begin
    // Reset and idle
    rstn = 1'b0;
    cyc(1);
    chk_on = 1'b1;
    cyc(1);
    rstn = 1'b1;
    cyc(20);
    chk("idle_stable", 32'(btn_stable_o), 32'd0);
    chk("idle_pend",   32'(pend_o),       32'd0);
    chk("idle_irq",    32'(irq_o),        32'd0);
    chk("idle_id",     32'(irq_id_o),     32'd0);

    // Clean press on button 0, enabled
    en_we = 1'b1; en_wdata = 5'b00001;
    cyc(1);
    en_we = 1'b0;
    btn_i[0] = 1'b1;
    cyc(5);
    chk("press_not_yet", 32'(btn_stable_o[0]), 32'd0);
    cyc(1);
    chk("press_stable", 32'(btn_stable_o[0]), 32'd1);
    chk("press_pend",   32'(pend_o[0]),       32'd1);
    chk("press_irq",    32'(irq_o),           32'd1);
    chk("press_id",     32'(irq_id_o),        32'd0);
    clr_we = 1'b1; clr_wdata = 5'b00001;
    cyc(1);
    clr_we = 1'b0;
    chk("clear_irq", 32'(irq_o), 32'd0);
    btn_i[0] = 1'b0;
    cyc(10);

    // Glitch of D-1 cycles is rejected
    btn_i[2] = 1'b1;
    cyc(3);
    btn_i[2] = 1'b0;
    cyc(10);
    chk("glitch_stable", 32'(btn_stable_o), 32'd0);
    chk("glitch_pend",   32'(pend_o),       32'd0);

    // Masked pending, then priority after enabling
    en_we = 1'b1; en_wdata = 5'b00000;
    cyc(1);
    en_we = 1'b0;
    btn_i = 5'b01010;
    cyc(8);
    chk("masked_pend", 32'(pend_o), 32'b01010);
    chk("masked_irq",  32'(irq_o),  32'd0);
    en_we = 1'b1; en_wdata = 5'b11111;
    cyc(1);
    en_we = 1'b0;
    chk("prio_irq", 32'(irq_o),    32'd1);
    chk("prio_id1", 32'(irq_id_o), 32'd1);
    clr_we = 1'b1; clr_wdata = 5'b00010;
    cyc(1);
    clr_we = 1'b0;
    chk("prio_id3", 32'(irq_id_o), 32'd3);
    btn_i = '0;
    cyc(10);
    clr_we = 1'b1; clr_wdata = 5'b11111;
    cyc(1);
    clr_we = 1'b0;

    // Clear of bit 4 on the very edge its press is accepted: set wins
    btn_i[4] = 1'b1;
    cyc(5);
    clr_we = 1'b1; clr_wdata = 5'b10000;
    cyc(1);
    clr_we = 1'b0;
    chk("collide_stable", 32'(btn_stable_o[4]), 32'd1);
    chk("collide_pend",   32'(pend_o[4]),       32'd1);
    btn_i[4] = 1'b0;
    cyc(10);
    clr_we = 1'b1; clr_wdata = 5'b11111;
    cyc(1);
    clr_we = 1'b0;

    // Reset at count 2 while button 0 is held
    btn_i[0] = 1'b1;
    cyc(4);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    cyc(5);
    chk("rst_hold_not_yet", 32'(btn_stable_o[0]), 32'd0);
    cyc(1);
    chk("rst_hold_stable", 32'(btn_stable_o[0]), 32'd1);
    chk("rst_hold_pend",   32'(pend_o),          32'b00001);
    btn_i[0] = 1'b0;
    cyc(10);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(15) == 0) btn_i[b] = ~btn_i[b];
      en_we     = ($urandom_range(19) == 0);
      en_wdata  = 5'($urandom);
      clr_we    = ($urandom_range(7) == 0);
      clr_wdata = 5'($urandom);
      rstn      = ($urandom_range(499) != 0);
      cyc(1);
    end
    rstn = 1'b1; en_we = 1'b0; clr_we = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
